// File: rtl/shift_unit_if.sv
// shift_unit_if: start/busy/done handshake bundle for the multi-cycle shifter.
//   master: control FSM side. It drives start, op, data_in and shamt, and
//           observes busy, done and data_out.
//   slave : the shifter side. It receives the request and returns status
//           and the result.
//   WIDTH sets the data width. SHAMT_W = $clog2(WIDTH) sets the
//   shift-amount width.
interface shift_unit_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   data_out;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, data_out
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, data_out
  );
endinterface

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle shifter that moves one bit per clock. It supports
// PASS, SLL, SRL, SRA, ROL and ROR with a run-time shift amount.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; it aborts any operation in flight
//   bus   : slave side of shift_unit_if
//           start/op/data_in/shamt are sampled only while busy is low.
//           busy is high during SHIFT and DONE.
//           done is a one-cycle pulse in the cycle the new data_out appears.
//           data_out is a registered result that holds until the next
//           operation completes.
// WIDTH must be a power of two and at least 4.
module shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  shift_unit_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  localparam logic [SHAMT_W-1:0] ZERO_CNT = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] ONE_CNT  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   work_r;
  logic [SHAMT_W-1:0] count_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   data_out_r;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH-1:0]   step_s;
  logic               pass_s;

  // One-bit step of the work register in the latched direction.
  always_comb begin
    step_s = work_r;
    case (op_r)
      OP_SLL:  step_s = {work_r[WIDTH-2:0], 1'b0};
      OP_SRL:  step_s = {1'b0, work_r[WIDTH-1:1]};
      OP_SRA:  step_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
      OP_ROL:  step_s = {work_r[WIDTH-2:0], work_r[WIDTH-1]};
      OP_ROR:  step_s = {work_r[0], work_r[WIDTH-1:1]};
      default: step_s = work_r;
    endcase
  end

  // The request completes immediately when its effective shift amount is zero.
  // That covers shamt==0, PASS and the reserved opcodes.
  always_comb begin
    pass_s = 1'b1;
    case (bus.op)
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: pass_s = (bus.shamt == ZERO_CNT);
      OP_PASS: pass_s = 1'b1;
      default: pass_s = 1'b1;
    endcase
  end

  // Control FSM and datapath registers. busy and done are registered next to
  // the state, so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      work_r     <= {WIDTH{1'b0}};
      count_r    <= ZERO_CNT;
      op_r       <= 3'b000;
      data_out_r <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            work_r  <= bus.data_in;
            count_r <= bus.shamt;
            op_r    <= bus.op;
            busy_r  <= 1'b1;
            if (pass_s) begin
              data_out_r <= bus.data_in;
              state_r    <= DONE;
              done_r     <= 1'b1;
            end else begin
              state_r <= SHIFT;
              done_r  <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        SHIFT: begin
          work_r  <= step_s;
          count_r <= count_r - ONE_CNT;
          busy_r  <= 1'b1;
          // Exiting at count==1 keeps the decrement from ever wrapping.
          if (count_r == ONE_CNT) begin
            data_out_r <= step_s;
            state_r    <= DONE;
            done_r     <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        DONE: begin
          // A start seen in this cycle is deliberately dropped.
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.data_out = data_out_r;
endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;

  shift_unit_if #(.WIDTH(W)) bus ();

  shift_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the whole shift is computed at once with plain arithmetic.
  function automatic logic [W-1:0] exp_result(input logic [2:0] o, input logic [W-1:0] d,
                                               input logic [4:0] s);
    logic [2*W-1:0] dd;
    logic [2*W-1:0] t;
    dd = {d, d};
    case (o)
      3'd1: return d << s;
      3'd2: return d >> s;
      3'd3: return W'($signed(d) >>> s);
      3'd4: begin t = dd << s; return t[2*W-1:W]; end
      3'd5: begin t = dd >> s; return t[W-1:0]; end
      default: return d;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [4:0] s);
    if (o >= 3'd1 && o <= 3'd5) return int'(s);
    return 0;
  endfunction

  // Issues one request at the current negedge. It returns the number of edges
  // from the start edge to done, the result, the number of done pulses seen,
  // and busy one cycle after done.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] d, input logic [4:0] s,
                       output int lat, output logic [W-1:0] res, output int pulses,
                       output logic busy_after, output int start_cyc);
    bus.start = 1'b1; bus.op = o; bus.data_in = d; bus.shamt = s;
    start_cyc = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'($urandom); bus.data_in = $urandom; bus.shamt = 5'($urandom);
    lat = 0;
    pulses = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = bus.data_out;
    if (bus.done) pulses++;
    @(negedge clk);
    busy_after = bus.busy;
    if (bus.done) pulses++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.data_in = '0; bus.shamt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b data_out=%h, required 0 0 00000000",
               bus.busy, bus.done, bus.data_out);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [9]  = '{3'd1, 3'd1, 3'd3, 3'd2, 3'd5, 3'd4, 3'd1, 3'd6, 3'd7};
    logic [31:0] din [9]  = '{32'h1, 32'hA, 32'h80000000, 32'h80000000, 32'h1,
                              32'h80000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678};
    logic [4:0]  sh  [9]  = '{5'd2, 5'd2, 5'd4, 5'd4, 5'd1, 5'd31, 5'd0, 5'd7, 5'd31};
    logic [31:0] expv [9] = '{32'h4, 32'h28, 32'hF8000000, 32'h08000000, 32'h80000000,
                              32'h40000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678};
    int          explat [9] = '{2, 2, 4, 4, 1, 31, 0, 0, 0};
    int lat, pulses, sc;
    logic [W-1:0] res;
    logic ba;
    for (int i = 0; i < 9; i++) begin
      do_op(ops[i], din[i], sh[i], lat, res, pulses, ba, sc);
      checks++;
      if (res !== expv[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, res, expv[i]);
      end
      checks++;
      if (lat !== explat[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, explat[i]);
      end
      checks++;
      if (ba !== 1'b0 || pulses !== 1) begin
        errors++;
        $display("FAIL directed_tail[%0d]: busy_after=%b pulses=%0d, required 0 and 1",
                 i, ba, pulses);
      end
    end
  endtask

  task automatic test_handshake_abuse();
    int pulses;
    logic [W-1:0] res;
    pulses = 0;
    res = '0;
    bus.start = 1'b1; bus.op = 3'd2; bus.data_in = 32'h000000F0; bus.shamt = 5'd4;
    @(negedge clk);                        // after edge k
    bus.start = 1'b0; bus.data_in = 32'hFFFFFFFF; bus.op = 3'd1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abuse_busy_rise: busy=%b, required 1", bus.busy);
    end
    @(negedge clk);                        // after k+1
    bus.start = 1'b1;                      // sampled at k+2
    @(negedge clk);                        // after k+2
    bus.start = 1'b0;
    @(negedge clk);                        // after k+3
    @(negedge clk);                        // after k+4: DONE cycle
    if (bus.done) begin pulses++; res = bus.data_out; end
    bus.start = 1'b1;                      // sampled at k+5 while in DONE
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abuse_busy_fall: busy=%b, required 0", bus.busy);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus.done) pulses++;
      @(negedge clk);
    end
    checks++;
    if (res !== 32'h0000000F) begin
      errors++;
      $display("FAIL abuse_result: got %h, required 0000000f", res);
    end
    checks++;
    if (pulses !== 1 || bus.data_out !== 32'h0000000F) begin
      errors++;
      $display("FAIL abuse_pulses: pulses=%0d data_out=%h, required 1 and 0000000f",
               pulses, bus.data_out);
    end
  endtask

  task automatic test_reset_mid_shift();
    int pulses, lat, sc;
    logic [W-1:0] res;
    logic ba;
    bus.start = 1'b1; bus.op = 3'd4; bus.data_in = $urandom | 32'h1; bus.shamt = 5'd20;
    @(negedge clk);                        // after edge k
    bus.start = 1'b0;
    repeat (4) @(negedge clk);             // after edge k+4
    reset = 1'b1;                          // sampled at k+5
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b done=%b data_out=%h, required 0 0 00000000",
               bus.busy, bus.done, bus.data_out);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: activity cycles=%0d, required 0", pulses);
    end
    do_op(3'd1, 32'h1, 5'd3, lat, res, pulses, ba, sc);
    checks++;
    if (res !== 32'h8 || lat !== 3) begin
      errors++;
      $display("FAIL midreset_fresh: got %h lat %0d, required 00000008 lat 3", res, lat);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [W-1:0] d, res, ev;
    logic [4:0] s;
    int lat, pulses, sc;
    logic ba;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      d = $urandom;
      s = 5'($urandom);
      ev = exp_result(o, d, s);
      do_op(o, d, s, lat, res, pulses, ba, sc);
      checks++;
      if (res !== ev || lat !== exp_latency(o, s)) begin
        errors++;
        $display("FAIL random[%0d] op=%0d d=%h s=%0d: got %h lat %0d, required %h lat %0d",
                 i, o, d, s, res, lat, ev, exp_latency(o, s));
      end
      checks++;
      if (ba !== 1'b0 || pulses !== 1 || bus.data_out !== ev) begin
        errors++;
        $display("FAIL random_hold[%0d]: busy=%b pulses=%0d data_out=%h, required 0 1 %h",
                 i, ba, pulses, bus.data_out, ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses, sc1, sc2, sc3;
    logic [W-1:0] res;
    logic ba;
    do_op(3'd3, 32'h40000000, 5'd5, lat, res, pulses, ba, sc1);
    do_op(3'd0, 32'h0BADF00D, 5'd9, lat, res, pulses, ba, sc2);
    do_op(3'd5, 32'h000000FF, 5'd8, lat, res, pulses, ba, sc3);
    checks++;
    if (sc2 - sc1 !== 7 || sc3 - sc2 !== 2) begin
      errors++;
      $display("FAIL back_to_back_spacing: got %0d and %0d, required 7 and 2",
               sc2 - sc1, sc3 - sc2);
    end
    checks++;
    if (res !== 32'hFF000000) begin
      errors++;
      $display("FAIL back_to_back_result: got %h, required ff000000", res);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    test_reset();
    test_directed();
    test_handshake_abuse();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1);
  end
endmodule
